dramw_combiner: RTL and testbench
=================================

Name: dramw_combiner

Overview:
- Parametrised successor to the DRAM write-collector output stage.
- Routes each ALU vector through an OR crossbar into cache-line slots, then combines consecutive beats for the same line address into one accumulated line.
- Emits a line only when the address changes, the line fills, or the stream ends. Beats whose mask is all zero are dropped.
- Emitted lines pass through an NBUF-deep output FIFO so the DRAM write port can stall without immediately back-pressuring the write pipeline.

Parameters:
GBW, 32, global address width
DBW, 16, data word width
VSIZE, 8, ALU vector lanes
CSIZE, 32, words per cache line
NBUF, 4, output FIFO depth (>=2)

Ports:
i_clk  in  1  clock
i_rst  in  1  synchronous active-high reset
dec_rdy  in  1  decoded-beat valid
dec_ack  out  1  decoded beat consumed
i_addr  in  GBW  line address of beat
i_dec  in  VSIZE x CSIZE  routing: i_dec[c][v]=1 sends lane v to slot c
i_islast  in  1  last beat using current ALU vector
i_eos  in  1  end of stream; force line out after this beat
alu_dat_rdy  in  1  ALU vector valid
alu_dat_ack  out  1  ALU vector consumed
i_alu_dat  in  DBW x VSIZE  ALU vector
dramw_rdy  out  1  FIFO head valid
dramw_ack  in  1  DRAM accepted head
o_dramwa  out  GBW  head line address
o_dramwd  out  DBW x CSIZE  head line data
o_dramw_mask  out  CSIZE  head byte-lane word mask
o_pending  out  1  accumulator valid or FIFO non-empty

Behaviour:
Handshake
- Producer holds rdy and data stable until ack.
- ack is asserted only while rdy is high.
- A transfer occurs in any cycle where ack=1.

Crossbar (combinational)
- nd[c] = OR over v of (i_dec[c][v] ? i_alu_dat[v] : 0).
- nm[c] = |i_dec[c].

State
- Accumulator: acc_v, acc_a, acc_d[CSIZE], acc_m.
- FIFO: cnt register, range 0..NBUF.

Beat acceptance
- beat = dec_rdy & alu_dat_rdy & (NBUF-cnt >= 2).
- dec_ack = beat.
- alu_dat_ack = beat & i_islast.
- The free-slot check uses registered cnt; a same-cycle pop does not count toward free space.

On an accepted beat (cycle T):
- nm==0: accumulator unchanged. If i_eos and acc_v, push acc and clear acc_v.
- !acc_v or i_addr==acc_a: merge into m = acc_m|nm, with d[c] = nm[c] ? nd[c] : acc_d[c] (newer data wins per slot).
  - If m all-ones or i_eos: push merged line and clear acc_v.
  - Otherwise: acc <= merged, acc_a <= i_addr.
- acc_v and address differs: push old acc first. The new beat then goes through the same full/eos rule. Up to two pushes occur in one cycle, in order old then new.

FIFO
- Pushes are written at T and visible on dramw_rdy/o_dramw* from T+1.
- Pop on dramw_ack.
- Simultaneous push and pop are legal: cnt += pushes - pop.
- Outputs show the head entry while cnt>0 and are held stable until ack.
- When cnt==0, dramw_rdy=0 and the o_dramw* values are don't-care.

Reset
- Clears acc_v, acc_a, acc_d, acc_m, cnt and FIFO pointers.
- Reset values: dramw_rdy=0, o_dramwa=0, o_dramwd=0, o_dramw_mask=0, o_pending=0.
- dec_ack and alu_dat_ack are 0 during reset.
- Reset mid-operation discards partial lines and queued lines.

Latency and ordering
- Minimum latency from beat to dramw_rdy is 1 cycle, when the line completes.
- Order of emitted lines equals order of completion.

Test Plan:
(CSIZE=4, VSIZE=2, NBUF=4)
1. Addr 0x40, dec slots {0,1} from lanes {0,1}, data {A,B}, then addr 0x40, slots {2,3}, data {C,D} -> one line, addr 0x40, data {A,B,C,D}, mask 4'b1111, dramw_rdy 1 cycle after second beat.
2. Addr 0x40 mask 0011 then addr 0x80 mask 0001 with i_eos -> two lines: (0x40, 0011) then (0x80, 0001), both pushed in the same cycle; o_pending=0 after both are acked.
3. Beat with all-zero i_dec, i_eos=0 -> no line emitted, dec_ack=1, acc unchanged; with i_islast=1, alu_dat_ack=1.
4. Overlap: addr 0x40 slot0=A then slot0=E, i_eos -> data[0]=E, mask 0001.
5. Hold dramw_ack=0 and drive 4 full lines -> cnt reaches 3 or 4, then dec_ack=0 while NBUF-cnt<2. Release ack -> lines drain in order, no loss or duplication.
6. Assert i_rst with 2 queued lines and a partial acc -> next cycle dramw_rdy=0, o_pending=0, all outputs 0.

Source files
------------

// File: rtl/dramw_combiner.sv
// dramw_combiner: DRAM write-line combiner with output FIFO.
//
// Each accepted beat routes ALU lanes into cache-line slots through an OR crossbar. Beats that
// target the same line address are merged into an accumulator. A line leaves the accumulator when
// it fills, when the address changes, or at end of stream. Finished lines queue in an NBUF-deep
// FIFO in front of the DRAM write port.
//
// Ports:
//   i_clk, i_rst                   clock, synchronous active-high reset
//   dec_rdy / dec_ack              decoded-beat handshake (i_addr, i_dec, i_islast, i_eos)
//   alu_dat_rdy / alu_dat_ack      ALU vector handshake (i_alu_dat); acked on i_islast beats
//   dramw_rdy / dramw_ack          FIFO head handshake (o_dramwa, o_dramwd, o_dramw_mask)
//   o_pending                      accumulator holds a partial line or FIFO is non-empty
module dramw_combiner #(
  parameter int unsigned GBW   = 32,
  parameter int unsigned DBW   = 16,
  parameter int unsigned VSIZE = 8,
  parameter int unsigned CSIZE = 32,
  parameter int unsigned NBUF  = 4
) (
  input  logic                             i_clk,
  input  logic                             i_rst,
  input  logic                             dec_rdy,
  output logic                             dec_ack,
  input  logic [GBW-1:0]                   i_addr,
  input  logic [CSIZE-1:0][VSIZE-1:0]      i_dec,
  input  logic                             i_islast,
  input  logic                             i_eos,
  input  logic                             alu_dat_rdy,
  output logic                             alu_dat_ack,
  input  logic [VSIZE-1:0][DBW-1:0]        i_alu_dat,
  output logic                             dramw_rdy,
  input  logic                             dramw_ack,
  output logic [GBW-1:0]                   o_dramwa,
  output logic [CSIZE-1:0][DBW-1:0]        o_dramwd,
  output logic [CSIZE-1:0]                 o_dramw_mask,
  output logic                             o_pending
);

  localparam int unsigned PW = (NBUF > 1) ? $clog2(NBUF) : 1;
  localparam int unsigned CW = $clog2(NBUF + 1);

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(NBUF - 1)) ? '0 : p + PW'(1);
  endfunction

  // Accumulator
  logic                       acc_v_q, acc_v_d;
  logic [GBW-1:0]             acc_a_q, acc_a_d;
  logic [CSIZE-1:0][DBW-1:0]  acc_d_q, acc_d_d;
  logic [CSIZE-1:0]           acc_m_q, acc_m_d;

  // FIFO
  logic [GBW-1:0]             mem_a_q [NBUF];
  logic [CSIZE-1:0][DBW-1:0]  mem_d_q [NBUF];
  logic [CSIZE-1:0]           mem_m_q [NBUF];
  logic [PW-1:0]              wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0]              cnt_q, cnt_d;

  logic [CSIZE-1:0][DBW-1:0]  nd, mrg_d;
  logic [CSIZE-1:0]           nm, mrg_m;
  logic                       beat, diff, keep, pop, push0, push1;
  logic [GBW-1:0]             e0_a;
  logic [CSIZE-1:0][DBW-1:0]  e0_d;
  logic [CSIZE-1:0]           e0_m;

  // OR crossbar: lane v lands in slot c when i_dec[c][v] is set.
  always_comb begin
    nd = '0;
    nm = '0;
    for (int c = 0; c < int'(CSIZE); c++) begin
      for (int v = 0; v < int'(VSIZE); v++) begin
        if (i_dec[c][v]) nd[c] = nd[c] | i_alu_dat[v];
      end
      nm[c] = |i_dec[c];
    end
  end

  always_comb begin
    // Two free slots are required since one beat may push two lines. A same-cycle pop is
    // deliberately not credited.
    beat        = dec_rdy & alu_dat_rdy & (cnt_q <= CW'(NBUF - 2)) & ~i_rst;
    dec_ack     = beat;
    alu_dat_ack = beat & i_islast;

    diff = acc_v_q && (i_addr != acc_a_q);
    // Merge onto the accumulator only if it holds a live line for this address.
    keep = acc_v_q && !diff;
    for (int c = 0; c < int'(CSIZE); c++) begin
      mrg_d[c] = nm[c] ? nd[c] : (keep ? acc_d_q[c] : '0);
    end
    mrg_m = nm | (keep ? acc_m_q : '0);

    acc_v_d = acc_v_q;
    acc_a_d = acc_a_q;
    acc_d_d = acc_d_q;
    acc_m_d = acc_m_q;
    push0   = 1'b0;
    push1   = 1'b0;
    e0_a    = acc_a_q;
    e0_d    = acc_d_q;
    e0_m    = acc_m_q;

    if (beat) begin
      if (nm == '0) begin
        if (i_eos && acc_v_q) begin
          push0   = 1'b1;
          acc_v_d = 1'b0;
        end
      end else if ((&mrg_m) || i_eos) begin
        acc_v_d = 1'b0;
        if (diff) begin
          // Old line goes first, merged line second.
          push0 = 1'b1;
          push1 = 1'b1;
        end else begin
          push0 = 1'b1;
          e0_a  = i_addr;
          e0_d  = mrg_d;
          e0_m  = mrg_m;
        end
      end else begin
        push0   = diff;
        acc_v_d = 1'b1;
        acc_a_d = i_addr;
        acc_d_d = mrg_d;
        acc_m_d = mrg_m;
      end
    end

    pop   = dramw_ack & (cnt_q != '0);
    cnt_d = cnt_q + CW'(push0) + CW'(push1) - CW'(pop);
    wr_d  = push1 ? ptr_inc(ptr_inc(wr_q)) : (push0 ? ptr_inc(wr_q) : wr_q);
    rd_d  = pop ? ptr_inc(rd_q) : rd_q;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      acc_v_q <= 1'b0;
      acc_a_q <= '0;
      acc_d_q <= '0;
      acc_m_q <= '0;
      wr_q    <= '0;
      rd_q    <= '0;
      cnt_q   <= '0;
      for (int i = 0; i < int'(NBUF); i++) begin
        mem_a_q[i] <= '0;
        mem_d_q[i] <= '0;
        mem_m_q[i] <= '0;
      end
    end else begin
      acc_v_q <= acc_v_d;
      acc_a_q <= acc_a_d;
      acc_d_q <= acc_d_d;
      acc_m_q <= acc_m_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      cnt_q   <= cnt_d;
      if (push0) begin
        mem_a_q[wr_q] <= e0_a;
        mem_d_q[wr_q] <= e0_d;
        mem_m_q[wr_q] <= e0_m;
      end
      if (push1) begin
        mem_a_q[ptr_inc(wr_q)] <= i_addr;
        mem_d_q[ptr_inc(wr_q)] <= mrg_d;
        mem_m_q[ptr_inc(wr_q)] <= mrg_m;
      end
    end
  end

  // Head outputs read as zero while the FIFO is empty.
  always_comb begin
    dramw_rdy    = (cnt_q != '0);
    o_dramwa     = dramw_rdy ? mem_a_q[rd_q] : '0;
    o_dramwd     = dramw_rdy ? mem_d_q[rd_q] : '0;
    o_dramw_mask = dramw_rdy ? mem_m_q[rd_q] : '0;
    o_pending    = acc_v_q | dramw_rdy;
  end

endmodule

// File: tb/tb_dramw_combiner.sv
module tb_dramw_combiner;

  localparam int unsigned GBW = 32, DBW = 16, VSIZE = 2, CSIZE = 4, NBUF = 4;

  logic                        clk = 1'b0;
  logic                        rst;
  logic                        dec_rdy, dec_ack, islast, eos;
  logic                        alu_rdy, alu_ack;
  logic [GBW-1:0]              addr;
  logic [CSIZE-1:0][VSIZE-1:0] dec;
  logic [VSIZE-1:0][DBW-1:0]   alu;
  logic                        dramw_rdy, dramw_ack, pending;
  logic [GBW-1:0]              dramwa;
  logic [CSIZE-1:0][DBW-1:0]   dramwd;
  logic [CSIZE-1:0]            dramw_mask;

  dramw_combiner #(.GBW(GBW), .DBW(DBW), .VSIZE(VSIZE), .CSIZE(CSIZE), .NBUF(NBUF)) dut (
    .i_clk(clk), .i_rst(rst),
    .dec_rdy(dec_rdy), .dec_ack(dec_ack), .i_addr(addr), .i_dec(dec),
    .i_islast(islast), .i_eos(eos),
    .alu_dat_rdy(alu_rdy), .alu_dat_ack(alu_ack), .i_alu_dat(alu),
    .dramw_rdy(dramw_rdy), .dramw_ack(dramw_ack), .o_dramwa(dramwa), .o_dramwd(dramwd),
    .o_dramw_mask(dramw_mask), .o_pending(pending)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        rst, drdy, ardy;
    logic [31:0] addr;
    logic [7:0]  dec;
    logic        islast, eos;
    logic [31:0] alu;
    logic        dack;
    logic        e_dack, e_aack, e_rdy;
    logic [31:0] e_addr;
    logic [63:0] e_data;
    logic [3:0]  e_mask;
    logic        e_pend;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(
    input logic r, dr, ar, input logic [31:0] a, input logic [7:0] d, input logic il, eo,
    input logic [31:0] al, input logic dk, input logic eda, eaa, erdy,
    input logic [31:0] ea, input logic [63:0] ed, input logic [3:0] em, input logic ep);
    vec_t v;
    v.rst = r; v.drdy = dr; v.ardy = ar; v.addr = a; v.dec = d; v.islast = il; v.eos = eo;
    v.alu = al; v.dack = dk; v.e_dack = eda; v.e_aack = eaa; v.e_rdy = erdy; v.e_addr = ea;
    v.e_data = ed; v.e_mask = em; v.e_pend = ep;
    return v;
  endfunction

  logic [31:0] exp_q[$];
  bit          acc3;

  initial begin
    rst = 1'b1; dec_rdy = 0; alu_rdy = 0; addr = '0; dec = '0; islast = 0; eos = 0;
    alu = '0; dramw_ack = 0;

    // Two beats filling one line
    vecs.push_back(mk(1,0,0,0,0,0,0,0,0, 0,0,0,0,0,0,0));
    vecs.push_back(mk(0,1,1,'h40,'h09,1,0,'hBBBBAAAA,0, 1,1,0,0,0,0,1));
    vecs.push_back(mk(0,1,1,'h40,'h90,1,0,'hDDDDCCCC,0, 1,1,1,'h40,'hDDDDCCCCBBBBAAAA,'hF,1));
    vecs.push_back(mk(0,0,0,0,0,0,0,0,1, 0,0,0,0,0,0,0));
    // Address change plus eos: two pushes in one cycle
    vecs.push_back(mk(0,1,1,'h40,'h09,1,0,'h22221111,0, 1,1,0,0,0,0,1));
    vecs.push_back(mk(0,1,1,'h80,'h01,1,1,'h44443333,0, 1,1,1,'h40,'h22221111,'h3,1));
    vecs.push_back(mk(0,0,0,0,0,0,0,0,1, 0,0,1,'h80,'h3333,'h1,1));
    vecs.push_back(mk(0,0,0,0,0,0,0,0,1, 0,0,0,0,0,0,0));
    // Zero-mask beat leaves the accumulator alone; islast=0 holds ALU vector
    vecs.push_back(mk(0,1,1,'h100,'h09,0,0,'h66665555,0, 1,0,0,0,0,0,1));
    vecs.push_back(mk(0,1,1,'h200,'h00,1,0,'h99999999,0, 1,1,0,0,0,0,1));
    vecs.push_back(mk(0,1,1,'h100,'h90,1,0,'h88887777,0, 1,1,1,'h100,'h8888777766665555,'hF,1));
    vecs.push_back(mk(0,0,0,0,0,0,0,0,1, 0,0,0,0,0,0,0));
    // Overlapping slot: newer data wins
    vecs.push_back(mk(0,1,1,'h40,'h01,1,0,'h0000AAAA,0, 1,1,0,0,0,0,1));
    vecs.push_back(mk(0,1,1,'h40,'h01,1,1,'h0000EEEE,0, 1,1,1,'h40,'hEEEE,'h1,1));
    vecs.push_back(mk(0,0,0,0,0,0,0,0,1, 0,0,0,0,0,0,0));
    // Zero-mask beat with eos flushes partial line
    vecs.push_back(mk(0,1,1,'h40,'h01,1,0,'h00001234,0, 1,1,0,0,0,0,1));
    vecs.push_back(mk(0,1,1,'h40,'h00,1,1,'h0,0, 1,1,1,'h40,'h1234,'h1,1));
    vecs.push_back(mk(0,0,0,0,0,0,0,0,1, 0,0,0,0,0,0,0));
    // ALU not ready: no beat
    vecs.push_back(mk(0,1,0,'h40,'h09,1,0,'h1,0, 0,0,0,0,0,0,0));
    // Two queued lines plus partial, then reset
    vecs.push_back(mk(0,1,1,'h40,'h55,1,0,'hAB01,0, 1,1,1,'h40,'hAB01AB01AB01AB01,'hF,1));
    vecs.push_back(mk(0,1,1,'h80,'h55,1,0,'hAB02,0, 1,1,1,'h40,'hAB01AB01AB01AB01,'hF,1));
    vecs.push_back(mk(0,1,1,'hC0,'h01,1,0,'hAB03,0, 1,1,1,'h40,'hAB01AB01AB01AB01,'hF,1));
    vecs.push_back(mk(1,1,1,'hC0,'h01,1,0,'hAB03,0, 0,0,0,0,0,0,0));
    vecs.push_back(mk(0,0,0,0,0,0,0,0,0, 0,0,0,0,0,0,0));

    foreach (vecs[i]) begin
      @(negedge clk);
      rst = vecs[i].rst; dec_rdy = vecs[i].drdy; alu_rdy = vecs[i].ardy; addr = vecs[i].addr;
      dec = vecs[i].dec; islast = vecs[i].islast; eos = vecs[i].eos; alu = vecs[i].alu;
      dramw_ack = vecs[i].dack;
      #1;
      chk($sformatf("v%0d dec_ack", i), 64'(dec_ack), 64'(vecs[i].e_dack));
      chk($sformatf("v%0d alu_ack", i), 64'(alu_ack), 64'(vecs[i].e_aack));
      @(posedge clk); #1;
      chk($sformatf("v%0d rdy", i), 64'(dramw_rdy), 64'(vecs[i].e_rdy));
      chk($sformatf("v%0d addr", i), 64'(dramwa), 64'(vecs[i].e_addr));
      chk($sformatf("v%0d data", i), 64'(dramwd), vecs[i].e_data);
      chk($sformatf("v%0d mask", i), 64'(dramw_mask), 64'(vecs[i].e_mask));
      chk($sformatf("v%0d pending", i), 64'(pending), 64'(vecs[i].e_pend));
    end

    // Back-pressure: full lines with DRAM stalled; the fourth must wait for credit
    dramw_ack = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      dec_rdy = 1; alu_rdy = 1; islast = 1; eos = 0; dec = 8'h55;
      addr = 32'h1000 + 32'(i) * 32'h40;
      alu = {16'h0, 16'h5000 + 16'(i)};
      #1;
      chk($sformatf("stall beat%0d dec_ack", i), 64'(dec_ack), 64'(i < 3));
      if (i < 3) exp_q.push_back(addr);
      @(posedge clk); #1;
    end
    acc3 = 0;
    for (int k = 0; k < 40 && !(acc3 && exp_q.size() == 0); k++) begin
      @(negedge clk);
      dramw_ack = dramw_rdy;
      #1;
      if (k == 0) chk("no credit for same-cycle pop", 64'(dec_ack), 64'(0));
      if (!acc3 && dec_ack) begin
        acc3 = 1;
        exp_q.push_back(32'h10C0);
      end
      if (dramw_rdy) begin
        if (exp_q.size() == 0) begin
          chk("drain extra line", 64'(dramwa), 64'hFFFF_FFFF_FFFF_FFFF);
        end else begin
          chk("drain addr", 64'(dramwa), 64'(exp_q[0]));
          chk("drain data", 64'(dramwd),
              {4{16'h5000 + 16'((exp_q[0] - 32'h1000) >> 6)}});
          void'(exp_q.pop_front());
        end
      end
      @(posedge clk); #1;
      if (acc3) dec_rdy = 0;
    end
    chk("fourth line accepted", 64'(acc3), 64'(1));
    chk("drain queue empty", 64'(exp_q.size()), 64'(0));
    @(negedge clk);
    dramw_ack = 0; dec_rdy = 0; alu_rdy = 0;
    #1;
    chk("after drain rdy", 64'(dramw_rdy), 64'(0));
    chk("after drain pending", 64'(pending), 64'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
